pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch sequencer for the RISC-V core.
//  Drives the PC+4 input of the branch next-PC mux and accepts the selected target back as a redirect.
//  Issues one word fetch at a time to instruction memory over a valid/ready request and a valid response.
//  Presents {instr, pc} to decode through a registered valid/ready output.
// PARAMETERS
//  XLEN      32            address/PC width
//  RESET_PC  32'h0000_0000 first fetch address after reset
//  NOP_INSTR 32'h0000_0013 value held on if_instr while not valid (addi x0,x0,0)
// PORTS
//  clk            in  1     single clock, all state on rising edge
//  rst_n          in  1     synchronous, active-low reset
//  pc_plus4       out XLEN  pc + 4; feeds the PC+4 input of the next-PC mux
//  redirect_valid in  1     branch/jump taken this cycle
//  redirect_pc    in  XLEN  next-PC mux output; bits [1:0] ignored (treated as 0)
//  imem_req_valid out 1     fetch request valid
//  imem_req_ready in  1     imem accepts request when valid&&ready
//  imem_addr      out XLEN  word-aligned fetch address (= pc)
//  imem_rsp_valid in  1     response data valid (one per accepted request, >=1 cycle later)
//  imem_rsp_data  in  32    fetched instruction word
//  if_valid       out 1     instruction available to decode
//  if_ready       in  1     decode accepts when if_valid&&if_ready
//  if_instr       out 32    fetched instruction
//  if_pc          out XLEN  address of if_instr
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_PC, state=S_REQ, drop=0, imem_req_valid=0 in the reset cycle,
//   if_valid=0, if_instr=NOP_INSTR, if_pc=0. pc_plus4=pc+4 combinationally, mod 2^XLEN (wraps).
//  FSM states: S_REQ, S_WAIT, S_HOLD. imem_req_valid=1 only in S_REQ with rst_n=1. imem_addr=pc always.
//  S_REQ: on valid&&ready -> S_WAIT. Until accepted, imem_addr may change only through a redirect.
//  S_WAIT: on imem_rsp_valid -> latch if_instr=rsp_data, if_pc=pc, if_valid=1 next cycle; -> S_HOLD.
//  S_HOLD: if_valid=1, if_instr/if_pc stable. On if_ready -> pc=pc+4, if_valid=0, if_instr=NOP_INSTR;
//   -> S_REQ.
//  Sustained throughput: 1 instruction per 3 cycles with 1-cycle imem latency and ready held high.
//  Redirect (redirect_valid=1) has priority over sequential update:
//   S_REQ, not yet accepted: pc=redirect_pc&~3; stay S_REQ; the old address is never accepted.
//   S_REQ, accepted same cycle: pc=redirect_pc; set drop=1; -> S_WAIT.
//   S_WAIT: pc=redirect_pc; set drop=1. A response arriving in the same cycle is discarded.
//   S_WAIT with drop=1: next imem_rsp_valid is discarded (if_valid stays 0); clear drop; -> S_REQ.
//   S_HOLD: if_valid=0 next cycle. If if_ready is also high, that handshake completes (instruction
//    consumed). pc=redirect_pc either way; -> S_REQ.
//  Back-to-back redirects: the last one wins. The drop flag is single-bit; at most one request is in flight.
//  imem_rsp_valid in S_REQ/S_HOLD: ignored (protocol error, no state change).
//  Reset asserted mid-fetch: all state returns to reset values. A late response after reset is ignored
//   (state is S_REQ).
//  if_ready while if_valid=0: no effect.
// TESTING
//  T1 reset, ready=1, 1-cycle imem: fetch addrs 0x0,0x4,0x8; if_pc matches; instrs in order; 3-cycle cadence.
//  T2 imem_req_ready low 4 cycles: imem_addr=0x4 held stable with valid=1; accepted on 5th cycle; no dup fetch.
//  T3 redirect_pc=0x100 in S_WAIT for addr 0x8: 0x8 response discarded, next request 0x100, if_pc=0x100.
//  T4 if_ready low 5 cycles in S_HOLD: if_instr/if_pc stable; redirect 0x40 with if_ready=1 -> consumed,
//   next fetch 0x40.
//  T5 RESET_PC=32'hFFFF_FFFC: pc_plus4=0x0; second fetch address 0x0 (wrap).
//  T6 rst_n low while in S_WAIT, response arrives after release: response ignored, first fetch RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Purpose: PC register plus single-outstanding instruction fetch sequencer feeding decode.
// Latency: request -> response (>=1 cycle) -> if_valid next cycle; 3 cycles/instr at 1-cycle imem.
// Backpressure: holds imem_addr until imem_req_ready; holds {instr, pc} until if_ready.
module pc_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    // Set when the in-flight request belongs to a squashed path; its response is thrown away.
    logic            drop;
    logic [XLEN-1:0] redir_tgt;
    logic            req_fire;

    // Fetches are always word aligned, so the low two target bits are forced to zero.
    assign redir_tgt      = redirect_pc & ~XLEN'(3);
    assign pc_plus4       = pc + XLEN'(4);
    assign imem_addr      = pc;
    assign imem_req_valid = (state == S_REQ) && rst_n;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Fetch sequencer: request, wait for the single outstanding response, hold for decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            if_pc    <= {XLEN{1'b0}};
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc <= redir_tgt;
                        // The old address went out this cycle; remember to discard its data.
                        if (req_fire) begin
                            drop  <= 1'b1;
                            state <= S_WAIT;
                        end
                    end else if (req_fire) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc <= redir_tgt;
                        // A response landing now is the stale one: request is done, refetch.
                        if (imem_rsp_valid) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            if_valid <= 1'b1;
                            if_instr <= imem_rsp_data;
                            if_pc    <= pc;
                            state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // A redirect squashes the held instruction unless decode takes it the same cycle.
                    if (redirect_valid || if_ready) begin
                        pc       <= redirect_valid ? redir_tgt : pc_plus4;
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                        state    <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Purpose: self-checking bench for pc_fetch_unit with an imem model and output scoreboard.
// Latency: imem model answers a configurable number of cycles after each accepted request.
// Backpressure: imem_req_ready and if_ready are driven per scenario from the main sequence.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } out_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    pc_fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_plus4       (pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    // Second instance exercising PC wrap-around from the top of the address space.
    logic        w_rst_n;
    logic [31:0] w_pc_plus4;
    logic        w_req_valid;
    logic [31:0] w_addr;
    logic        w_rsp_valid;
    logic        w_if_valid;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .rst_n          (w_rst_n),
        .pc_plus4       (w_pc_plus4),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (1'b1),
        .imem_addr      (w_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (32'h0000_0033),
        .if_valid       (w_if_valid),
        .if_ready       (1'b1),
        .if_instr       (w_if_instr),
        .if_pc          (w_if_pc)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] exp_fetch[$];
    out_t        exp_out[$];
    int          cons_cyc[$];
    logic [31:0] w_exp[$];
    int          lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    bit          poison = 1'b0;
    bit          w_pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F01;
    endfunction

    function automatic out_t mk_out(input logic [31:0] a);
        return {a, imem_word(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Imem model: checks every accepted address against the expected fetch list.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = poison ? 32'hDEAD_BEEF : imem_word(pend_addr);
                    poison         = 1'b0;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_cnt  = lat;
                pend_addr = imem_addr;
                if (exp_fetch.size() == 0) chk("imem_extra_req", exp_fetch.size(), 1);
                else chk("imem_addr", imem_addr, exp_fetch.pop_front());
            end
        end
    end

    // Decode-side monitor: every consumed instruction must match the scoreboard head.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (rst_n && if_valid && if_ready) begin
                cons_cyc.push_back(cyc);
                if (exp_out.size() == 0) chk("if_extra_out", exp_out.size(), 1);
                else begin
                    e = exp_out.pop_front();
                    chk("if_pc", if_pc, e.pc);
                    chk("if_instr", if_instr, e.instr);
                end
            end
        end
    end

    // Wrap instance imem: fixed 1-cycle latency, always ready.
    initial begin
        w_rsp_valid = 1'b0;
        forever begin
            @(negedge clk);
            w_rsp_valid = w_pend;
            w_pend      = 1'b0;
            if (w_req_valid) begin
                w_pend = 1'b1;
                if (w_exp.size() > 0) chk("t5_fetch_addr", w_addr, w_exp.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        if_ready       = 1'b1;
        lat            = 1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_out.size() != 0 || exp_fetch.size() != 0) && n < 100) begin
            step();
            n++;
        end
        imem_req_ready = 1'b0;
        chk(tag, n < 100, 1);
        exp_out.delete();
        exp_fetch.delete();
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        if_ready       = 1'b1;
        w_rst_n        = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_instr", if_instr, NOP);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_pc_plus4", pc_plus4, 4);

        // T1: sequential fetch, 3-cycle cadence
        exp_fetch = '{32'h0, 32'h4, 32'h8};
        exp_out.push_back(mk_out(32'h0));
        exp_out.push_back(mk_out(32'h4));
        exp_out.push_back(mk_out(32'h8));
        cons_cyc.delete();
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        wait_done("t1_done");
        chk("t1_count", cons_cyc.size(), 3);
        if (cons_cyc.size() == 3) begin
            chk("t1_cadence_a", cons_cyc[1] - cons_cyc[0], 3);
            chk("t1_cadence_b", cons_cyc[2] - cons_cyc[1], 3);
        end

        // T2: request stalled by imem_req_ready for 4 cycles
        do_reset();
        exp_fetch = '{32'h0, 32'h4};
        exp_out.push_back(mk_out(32'h0));
        exp_out.push_back(mk_out(32'h4));
        imem_req_ready = 1'b1;
        n = 0;
        while (!(imem_req_valid && imem_addr == 32'h4) && n < 30) begin step(); n++; end
        chk("t2_reach", n < 30, 1);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_hold_vld", imem_req_valid, 1);
            chk("t2_hold_addr", imem_addr, 32'h4);
        end
        imem_req_ready = 1'b1;
        step();
        chk("t2_accepted", imem_req_valid, 0);
        wait_done("t2_done");

        // T3: redirect in S_WAIT coinciding with the response
        do_reset();
        exp_fetch = '{32'h0, 32'h4, 32'h8, 32'h100};
        exp_out.push_back(mk_out(32'h0));
        exp_out.push_back(mk_out(32'h4));
        exp_out.push_back(mk_out(32'h100));
        imem_req_ready = 1'b1;
        n = 0;
        while (!(!imem_req_valid && imem_addr == 32'h8) && n < 30) begin step(); n++; end
        chk("t3_reach", n < 30, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("t3_redir_addr", imem_addr, 32'h100);
        chk("t3_redir_vld", imem_req_valid, 1);
        chk("t3_no_out", if_valid, 0);
        wait_done("t3_done");

        // T3b: redirect in S_WAIT before a slow response; stale data dropped, low bits masked
        do_reset();
        lat = 3;
        exp_fetch = '{32'h0, 32'h4, 32'h8, 32'h100};
        exp_out.push_back(mk_out(32'h0));
        exp_out.push_back(mk_out(32'h4));
        exp_out.push_back(mk_out(32'h100));
        imem_req_ready = 1'b1;
        n = 0;
        while (!(!imem_req_valid && imem_addr == 32'h8) && n < 40) begin step(); n++; end
        chk("t3b_reach", n < 40, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        step();
        redirect_valid = 1'b0;
        chk("t3b_addr", imem_addr, 32'h100);
        chk("t3b_plus4", pc_plus4, 32'h104);
        chk("t3b_waiting", imem_req_valid, 0);
        wait_done("t3b_done");

        // T4: decode stall then redirect with if_ready in S_HOLD
        do_reset();
        exp_fetch = '{32'h0};
        exp_out.push_back(mk_out(32'h0));
        if_ready       = 1'b0;
        imem_req_ready = 1'b1;
        n = 0;
        while (!if_valid && n < 30) begin step(); n++; end
        chk("t4_reach", n < 30, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_vld", if_valid, 1);
            chk("t4_hold_instr", if_instr, imem_word(32'h0));
            chk("t4_hold_pc", if_pc, 32'h0);
        end
        exp_fetch.push_back(32'h40);
        exp_out.push_back(mk_out(32'h40));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        if_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("t4_after_vld", if_valid, 0);
        chk("t4_after_instr", if_instr, NOP);
        chk("t4_after_addr", imem_addr, 32'h40);
        wait_done("t4_done");

        // T7: redirects in S_REQ, unaccepted then accepted in the same cycle
        do_reset();
        step();
        chk("t7_req_vld", imem_req_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        chk("t7_redir_addr", imem_addr, 32'h200);
        chk("t7_redir_vld", imem_req_valid, 1);
        exp_fetch = '{32'h200, 32'h300};
        exp_out.push_back(mk_out(32'h300));
        redirect_pc    = 32'h300;
        imem_req_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("t7_fired", imem_req_valid, 0);
        chk("t7_new_addr", imem_addr, 32'h300);
        wait_done("t7_done");

        // T6: reset during S_WAIT; the late response must be ignored
        do_reset();
        lat = 3;
        exp_fetch = '{32'h0};
        imem_req_ready = 1'b1;
        step();
        chk("t6_in_wait", imem_req_valid, 0);
        rst_n          = 1'b0;
        poison         = 1'b1;
        imem_req_ready = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_rst_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_req_vld", imem_req_valid, 1);
            chk("t6_no_out", if_valid, 0);
        end
        lat = 1;
        exp_fetch.push_back(32'h0);
        exp_out.push_back(mk_out(32'h0));
        imem_req_ready = 1'b1;
        wait_done("t6_done");

        // T5: PC wrap from 0xFFFF_FFFC
        chk("t5_plus4", w_pc_plus4, 32'h0);
        chk("t5_reset_addr", w_addr, 32'hFFFF_FFFC);
        w_exp = '{32'hFFFF_FFFC, 32'h0};
        w_rst_n = 1'b1;
        n = 0;
        while (w_exp.size() != 0 && n < 30) begin step(); n++; end
        chk("t5_done", n < 30, 1);
        w_rst_n = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
